mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between two requesters.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the CPU
// control path (port C) and the DMA/program loader (port D).
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt_id,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              grant, win;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              acc;
    logic              last;

    assign acc  = (state == ACCESS);
    assign last = acc && (cnt == '0);

    // Ties go to the port that did not win last time
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        win       = gnt_id;
        unique case (state)
            IDLE: begin
                if (c_req && d_req) begin
                    grant = 1'b1;
                    win   = ~gnt_id;
                end else if (c_req) begin
                    grant = 1'b1;
                    win   = 1'b0;
                end else if (d_req) begin
                    grant = 1'b1;
                    win   = 1'b1;
                end
                if (grant) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CW'(LAT - 1);
                end
            end
            ACCESS: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt_id  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (grant) begin
                gnt_id  <= win;
                we_q    <= win ? d_we    : c_we;
                addr_q  <= win ? d_addr  : c_addr;
                wdata_q <= win ? d_wdata : c_wdata;
            end
            if (last && !we_q) rdata <= mem_rdata;
        end
    end

    // Memory bus is driven only from the latched request, never the live ports
    assign mem_addr  = acc ? addr_q  : '0;
    assign mem_wdata = acc ? wdata_q : '0;
    assign mem_we    = acc &  we_q;
    assign mem_re    = acc & ~we_q;
    assign busy      = (state != IDLE);
    assign c_done    = (state == DONE) & ~gnt_id;
    assign d_done    = (state == DONE) &  gnt_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus scoreboard of expected
// completions, with hand sequences for arbitration and reset corners.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_done, d_done, busy, gnt_id, mem_we, mem_re;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        c1_req, c1_we, d1_req, d1_we;
    logic [31:0] c1_addr, c1_wdata, d1_addr, d1_wdata;
    logic        c1_done, d1_done, busy1, gnt1_id, mem1_we, mem1_re;
    logic [31:0] rdata1, mem1_addr, mem1_wdata, mem1_rdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a * 32'd3 + 32'h1000);
    endfunction

    assign mem_rdata  = mem_model(mem_addr);
    assign mem1_rdata = mem_model(mem1_addr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done),
        .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .c_req(c1_req), .c_we(c1_we), .c_addr(c1_addr), .c_wdata(c1_wdata),
        .c_done(c1_done),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_done(d1_done),
        .rdata(rdata1), .busy(busy1), .gnt_id(gnt1_id),
        .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
        .mem_we(mem1_we), .mem_re(mem1_re), .mem_rdata(mem1_rdata)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    vec_t tbl[5];
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   inv_err = 0;

    always @(negedge clk) begin
        if ((mem_we && mem_re) || (c_done && d_done) ||
            (mem1_we && mem1_re) || (c1_done && d1_done))
            inv_err++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (!port) begin
            c_req = req; c_we = we; c_addr = a; c_wdata = wd;
        end else begin
            d_req = req; d_we = we; d_addr = a; d_wdata = wd;
        end
    endtask

    task automatic check_done(input logic port);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("done_port", 32'(port), 32'(e.port));
            chk("rdata", rdata, e.rdata);
        end
    endtask

    task automatic wait_done(input int budget, output int cyc,
                             output logic port, output logic to);
        to = 1'b1; cyc = 0; port = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (c_done || d_done) begin
                cyc = i; port = d_done; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_done1(input int budget, output int cyc,
                              output logic to);
        to = 1'b1; cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (c1_done || d1_done) begin
                cyc = i; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_txn(input vec_t v);
        int   acc, n;
        logic bad, to, p;
        @(posedge clk); #1;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        sb.push_back('{v.port, v.exp_rdata});
        acc = 0; n = 0; bad = 1'b0; to = 1'b1; p = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_re || mem_we) begin
                acc++;
                if (mem_addr !== v.addr || mem_we !== v.we ||
                    mem_re !== !v.we || (v.we && mem_wdata !== v.wdata))
                    bad = 1'b1;
            end else if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                bad = 1'b1;
            end
            if (c_done || d_done) begin
                n = i; p = d_done; to = 1'b0;
                break;
            end
        end
        chk("txn_timeout", 32'(to), 32'd0);
        chk("latency", 32'(n), 32'(LAT + 2));
        chk("mem_cycles", 32'(acc), 32'(LAT));
        chk("mem_bus", 32'(bad), 32'd0);
        chk("gnt_id", 32'(gnt_id), 32'(v.port));
        check_done(p);
        @(posedge clk); #1;
        drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("done_pulse", 32'(c_done | d_done), 32'd0);
    endtask

    task automatic do_reset;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int   cyc;
        logic p, to, seen;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = 32'h0; c1_wdata = 32'h0;
        d1_req = 1'b0; d1_we = 1'b0; d1_addr = 32'h0; d1_wdata = 32'h0;

        tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 1'b0, 32'h80, 32'h0,         32'h0000_1180};
        tbl[3] = '{1'b0, 1'b1, 32'h84, 32'hCAFE_F00D, 32'h0000_1180};
        tbl[4] = '{1'b0, 1'b0, 32'h00, 32'h0,         32'h0000_1000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem", {28'h0, mem_we, mem_re, c_done, d_done}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_gnt1_id", 32'(gnt1_id), 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        foreach (tbl[k]) do_txn(tbl[k]);

        // D raised while C is mid-access: waits, then wins the next IDLE
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        sb.push_back('{1'b0, mem_model(32'h20)});
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
        sb.push_back('{1'b1, mem_model(32'h44)});
        chk("t4_addr_a", mem_addr, 32'h20);
        @(negedge clk);
        chk("t4_addr_b", mem_addr, 32'h20);
        chk("t4_gnt", 32'(gnt_id), 32'd0);
        wait_done(5, cyc, p, to);
        chk("t4_c_timeout", 32'(to), 32'd0);
        check_done(p);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done(10, cyc, p, to);
        chk("t4_d_timeout", 32'(to), 32'd0);
        chk("t4_d_latency", 32'(cyc), 32'(LAT + 2));
        check_done(p);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Both requesting from reset: strict alternation starting with C
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int k = 0; k < 4; k++)
            sb.push_back('{k[0], mem_model(k[0] ? 32'h200 : 32'h100)});
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_done(12, cyc, p, to);
            chk("t3_timeout", 32'(to), 32'd0);
            if (k > 0) chk("t3_gap", 32'(cyc), 32'(LAT + 2));
            check_done(p);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during a DMA write
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 32'h60, 32'hA5A5_A5A5);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_we_seen", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_we", 32'(mem_we), 32'd0);
        chk("t5_re", 32'(mem_re), 32'd0);
        chk("t5_gnt_id", 32'(gnt_id), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (c_done || d_done) seen = 1'b1;
        end
        chk("t5_no_done", 32'(seen), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
        sb.push_back('{1'b0, mem_model(32'h30)});
        sb.push_back('{1'b1, mem_model(32'h34)});
        wait_done(10, cyc, p, to);
        chk("t5_tie_timeout", 32'(to), 32'd0);
        check_done(p);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done(10, cyc, p, to);
        chk("t5_d_timeout", 32'(to), 32'd0);
        check_done(p);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // LAT=1 instance: back-to-back CPU reads complete every 3rd cycle
        @(posedge clk); #1;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h10;
        wait_done1(10, cyc, to);
        chk("t6_first_timeout", 32'(to), 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_done1(10, cyc, to);
            chk("t6_timeout", 32'(to), 32'd0);
            chk("t6_gap", 32'(cyc), 32'd3);
            chk("t6_port", 32'(c1_done), 32'd1);
            chk("t6_rdata", rdata1, 32'hDEAD_BEEF);
        end
        @(posedge clk); #1 c1_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("invariants", 32'(inv_err), 32'd0);
        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
